// File: rtl/sprite_bitmap_writer_if.sv
// ============================================================================
// Module   : sprite_bitmap_writer_if
// Purpose  : Host-to-sprite-store row write channel (valid/ready plus a
//            restart strobe that abandons a partially written image).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sprite_bitmap_writer_if #(
  parameter int WIDTH = 8
);
  logic             wr_valid;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready;
  logic             wr_restart;

  // Host side: drives rows, observes acceptance
  modport master (
    output wr_valid,
    output wr_data,
    output wr_restart,
    input  wr_ready
  );

  // Sprite store side: consumes rows, reports acceptance
  modport slave (
    input  wr_valid,
    input  wr_data,
    input  wr_restart,
    output wr_ready
  );
endinterface

`default_nettype wire

// File: rtl/sprite_bitmap_writer.sv
// ============================================================================
// Module   : sprite_bitmap_writer
// Purpose  : Double-buffered writable sprite bitmap. The host fills the back
//            bank one row per beat; the finished image is swapped to the front
//            bank on the next vsync rising edge so the renderer's
//            combinational row lookup never shows a half-written sprite.
// Options  : SPRITE_WRITER_HMIRROR_EN - store each accepted row bit-reversed
//            (horizontal mirror applied at write time).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_bitmap_writer #(
  parameter int WIDTH = 8,
  parameter int ROWS  = 16
) (
  input  wire logic                    clk,
  input  wire logic                    reset,    // synchronous, active-low
  input  wire logic                    vsync,
  sprite_bitmap_writer_if.slave        wr,
  input  wire logic [$clog2(ROWS)-1:0] yofs,
  output logic      [WIDTH-1:0]        bits,
  output logic                         pending,
  output logic                         swapped
);

  localparam int AW = $clog2(ROWS);
  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

  typedef enum logic [0:0] {
    FILL      = 1'b0,
    WAIT_SWAP = 1'b1
  } state_t;

  state_t           state_q;
  logic             front_q;
  logic [AW-1:0]    row_cnt_q;
  logic             vsync_q;
  logic             swapped_q;
  logic [WIDTH-1:0] bank_q [2][ROWS];

  logic             vsync_rise;
  logic [WIDTH-1:0] row_store;

  // Frame start: vsync high now, low last cycle
  assign vsync_rise = vsync & ~vsync_q;

  // Row value as it lands in the back bank
`ifdef SPRITE_WRITER_HMIRROR_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_hmirror
    assign row_store[i] = wr.wr_data[WIDTH-1-i];
  end
`else
  assign row_store = wr.wr_data;
`endif

  // Acceptance depends only on state and restart, and is held off during reset
  assign wr.wr_ready = reset & (state_q == FILL) & ~wr.wr_restart;
  assign pending     = reset & (state_q == WAIT_SWAP);
  assign swapped     = reset & swapped_q;

  // Renderer lookup: front bank, zero latency
  assign bits = bank_q[front_q][yofs];

  // Fill / wait-for-swap sequencing, bank writes and buffer swap
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          bank_q[b][r] <= '0;
        end
      end
      front_q   <= 1'b0;
      row_cnt_q <= '0;
      state_q   <= FILL;
      vsync_q   <= 1'b0;
      swapped_q <= 1'b0;
    end else begin
      vsync_q   <= vsync;
      swapped_q <= 1'b0;
      case (state_q)
        FILL: begin
          // A vsync edge here is deliberately dropped: no complete image yet
          if (wr.wr_restart) begin
            row_cnt_q <= '0;
          end else if (wr.wr_valid) begin
            bank_q[~front_q][row_cnt_q] <= row_store;
            if (row_cnt_q == LAST_ROW) begin
              row_cnt_q <= '0;
              state_q   <= WAIT_SWAP;
            end else begin
              row_cnt_q <= row_cnt_q + AW'(1);
            end
          end
        end
        WAIT_SWAP: begin
          // Completed image is locked in; only a fresh frame start releases it
          if (vsync_rise) begin
            front_q   <= ~front_q;
            state_q   <= FILL;
            swapped_q <= 1'b1;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sprite_bitmap_writer.sv
// ============================================================================
// Module   : tb_sprite_bitmap_writer
// Purpose  : Self-checking bench for sprite_bitmap_writer (WIDTH=8, ROWS=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_bitmap_writer;

  localparam int WIDTH = 8;
  localparam int ROWS  = 16;

  typedef struct {
    logic [7:0] din;
    logic [3:0] yofs;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       vsync;
  logic [3:0] yofs;
  logic [7:0] bits;
  logic       pending;
  logic       swapped;

  sprite_bitmap_writer_if #(.WIDTH(WIDTH)) wif ();

  sprite_bitmap_writer #(.WIDTH(WIDTH), .ROWS(ROWS)) dut (
    .clk     (clk),
    .reset   (reset),
    .vsync   (vsync),
    .wr      (wif.slave),
    .yofs    (yofs),
    .bits    (bits),
    .pending (pending),
    .swapped (swapped)
  );

  always #5 clk = ~clk;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] mb [2][16];
  bit         mf;
  int         mrow;
  logic [7:0] exp_q [$];
  vec_t       tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference for what a written row becomes inside the store
  function automatic logic [7:0] mstore(input logic [7:0] d);
    logic [7:0] r;
`ifdef SPRITE_WRITER_HMIRROR_EN
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
`else
    r = d;
`endif
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 16; r++) mb[b][r] = 8'h00;
    mf   = 1'b0;
    mrow = 0;
  endtask

  // One accepted beat in FILL; vs is the vsync level during that beat
  task automatic load_row(input logic [7:0] d, input logic vs);
    wif.wr_valid = 1'b1;
    wif.wr_data  = d;
    vsync        = vs;
    #1;
    check("wr_ready_fill", {31'd0, wif.wr_ready}, 32'd1);
    step();
    mb[!mf][mrow] = mstore(d);
    mrow = (mrow + 1) % 16;
    wif.wr_valid = 1'b0;
  endtask

  task automatic read_all(input string name);
    for (int r = 0; r < 16; r++) begin
      yofs = r[3:0];
      #1;
      check(name, {24'd0, bits}, {24'd0, exp_q.pop_front()});
    end
  endtask

  // Raise vsync with a completed image waiting; verify pulse and new front
  task automatic do_swap();
    vsync = 1'b1;
    #1;
    check("swapped_before", {31'd0, swapped}, 32'd0);
    for (int r = 0; r < 16; r++) exp_q.push_back(mb[!mf][r]);
    mf = !mf;
    step();
    check("swapped_pulse", {31'd0, swapped}, 32'd1);
    check("pending_clear", {31'd0, pending}, 32'd0);
    vsync = 1'b0;
    step();
    check("swapped_single", {31'd0, swapped}, 32'd0);
    read_all("front_row");
  endtask

  initial begin
    tbl[0]  = '{8'h00, 4'd0};  tbl[1]  = '{8'h0C, 4'd1};
    tbl[2]  = '{8'hCC, 4'd2};  tbl[3]  = '{8'h33, 4'd3};
    tbl[4]  = '{8'hF0, 4'd4};  tbl[5]  = '{8'h0F, 4'd5};
    tbl[6]  = '{8'hAA, 4'd6};  tbl[7]  = '{8'h55, 4'd7};
    tbl[8]  = '{8'h81, 4'd8};  tbl[9]  = '{8'h7E, 4'd9};
    tbl[10] = '{8'h3C, 4'd10}; tbl[11] = '{8'hC3, 4'd11};
    tbl[12] = '{8'h18, 4'd12}; tbl[13] = '{8'hE7, 4'd13};
    tbl[14] = '{8'h01, 4'd14}; tbl[15] = '{8'h2E, 4'd15};

    reset = 1'b0; vsync = 1'b0; yofs = 4'd0;
    wif.wr_valid = 1'b0; wif.wr_data = 8'h00; wif.wr_restart = 1'b0;
    model_reset();

    // Reset state
    repeat (3) step();
    check("rst_wr_ready", {31'd0, wif.wr_ready}, 32'd0);
    check("rst_pending",  {31'd0, pending}, 32'd0);
    check("rst_swapped",  {31'd0, swapped}, 32'd0);
    for (int r = 0; r < 16; r++) exp_q.push_back(8'h00);
    read_all("rst_bits");
    reset = 1'b1;
    #1;
    check("wr_ready_after_rst", {31'd0, wif.wr_ready}, 32'd1);

    // Full-rate load from the vector table
    for (int i = 0; i < 16; i++) load_row(tbl[i].din, 1'b0);
    #1;
    check("pending_full", {31'd0, pending}, 32'd1);
    yofs = 4'd2;
    #1;
    check("bits_before_swap", {24'd0, bits}, 32'd0);

    // Backpressure in WAIT_SWAP: valid and restart both ignored
    wif.wr_valid = 1'b1; wif.wr_data = 8'hFF; wif.wr_restart = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("wr_ready_wait", {31'd0, wif.wr_ready}, 32'd0);
      step();
      check("pending_hold", {31'd0, pending}, 32'd1);
    end
    wif.wr_valid = 1'b0; wif.wr_restart = 1'b0;
    step();

    do_swap();
    for (int i = 0; i < 16; i++) begin
      yofs = tbl[i].yofs;
      #1;
      check("table_row", {24'd0, bits}, {24'd0, mstore(tbl[i].din)});
    end
    yofs = 4'd2;
    #1;
`ifdef SPRITE_WRITER_HMIRROR_EN
    check("row2_value", {24'd0, bits}, 32'h33);
`else
    check("row2_value", {24'd0, bits}, 32'hCC);
`endif

    // Restart after 5 rows: the restart beat must not write or advance
    for (int i = 0; i < 5; i++) load_row(8'hA0 + 8'(i), 1'b0);
    wif.wr_valid = 1'b1; wif.wr_data = 8'hFF; wif.wr_restart = 1'b1;
    #1;
    check("wr_ready_restart", {31'd0, wif.wr_ready}, 32'd0);
    step();
    wif.wr_valid = 1'b0; wif.wr_restart = 1'b0;
    mrow = 0;
    for (int i = 0; i < 16; i++) load_row(8'(i * 17) ^ 8'h5A, 1'b0);
    do_swap();

    // Last beat coincides with vsync rising: that edge is not used
    for (int i = 0; i < 15; i++) load_row(8'(i * 29 + 3), 1'b0);
    load_row(8'h96, 1'b1);
    check("pending_collide", {31'd0, pending}, 32'd1);
    check("no_swap_collide", {31'd0, swapped}, 32'd0);
    step();
    check("pending_vsync_high", {31'd0, pending}, 32'd1);
    check("no_swap_level", {31'd0, swapped}, 32'd0);
    vsync = 1'b0;
    step();
    do_swap();

    // Mid-fill reset with an image in front
    for (int i = 0; i < 10; i++) load_row(8'hC0 | 8'(i), 1'b0);
    reset = 1'b0;
    step();
    check("mid_rst_ready",   {31'd0, wif.wr_ready}, 32'd0);
    check("mid_rst_pending", {31'd0, pending}, 32'd0);
    model_reset();
    for (int r = 0; r < 16; r++) exp_q.push_back(8'h00);
    read_all("mid_rst_bits");
    reset = 1'b1;
    step();

    // Fresh load after reset starts at row 0; row 1 is the mirror probe
    for (int i = 0; i < 16; i++) load_row((i == 1) ? 8'b0000_1100 : 8'(i + 8'h40), 1'b0);
    do_swap();
    yofs = 4'd1;
    #1;
`ifdef SPRITE_WRITER_HMIRROR_EN
    check("mirror_row1", {24'd0, bits}, 32'h30);
`else
    check("plain_row1", {24'd0, bits}, 32'h0C);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
